// File: rtl/tc4_accumulator.sv
// rtl/tc4_accumulator.sv - signed 4-bit push-button accumulator with debounced keys
//
// Purpose: each debounced press of the add or subtract key adds or subtracts
// the switch operand sw_b, in two's complement, to/from the 4-bit value N.
// The clear key zeroes N and the sticky overflow flag.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   sw_b       operand B, two's complement, quasi-static slide switches
//   key_add_n  raw active-low add button (asynchronous to clk)
//   key_sub_n  raw active-low subtract button (asynchronous to clk)
//   key_clr_n  raw active-low clear button (asynchronous to clk)
//   N          accumulator value, two's complement
//   ovf        sticky signed-overflow flag
//   op_done    one-cycle pulse in the cycle N shows a new value

module tc4_accumulator #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] sw_b,
  input  logic       key_add_n,
  input  logic       key_sub_n,
  input  logic       key_clr_n,
  output logic [3:0] N,
  output logic       ovf,
  output logic       op_done
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Key lanes: bit 0 = add, bit 1 = sub, bit 2 = clear.
  logic [2:0]    key_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [2:0]    deb_d;
  logic [2:0]    press;
  logic [CW-1:0] cnt [3];

  assign key_raw = {key_clr_n, key_sub_n, key_add_n};

  // Synchronizer, debouncer and press detector for all three keys.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      deb_d <= '1;
      press <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      deb_d <= deb;
      // Registered falling edge of the debounced level; releases give nothing.
      press <= deb_d & ~deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Add and sub landing in the same cycle cancel each other out.
  logic       do_add;
  logic       do_sub;
  logic [3:0] b_eff;
  logic [3:0] sum;
  logic       ovf_now;

  assign do_add = press[0] & ~press[1];
  assign do_sub = press[1] & ~press[0];

  // Subtraction is N + ~sw_b + 1, so one adder covers both operations and
  // the overflow test is the same on the effective operand.
  always_comb begin
    b_eff   = do_sub ? ~sw_b : sw_b;
    sum     = N + b_eff + {3'b000, do_sub};
    ovf_now = (N[3] == b_eff[3]) && (sum[3] != N[3]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      N       <= 4'b0000;
      ovf     <= 1'b0;
      op_done <= 1'b0;
    end else begin
      op_done <= 1'b0;
      if (press[2]) begin
        N       <= 4'b0000;
        ovf     <= 1'b0;
        op_done <= 1'b1;
      end else if (do_add || do_sub) begin
        N       <= sum;
        op_done <= 1'b1;
        if (ovf_now) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/tc4_accumulator.md
Name: tc4_accumulator

Overview:
- Signed 4-bit accumulator driven by push-buttons and switches.
- Each debounced press adds or subtracts the switch operand B, in two's complement.
- It produces the 4-bit two's complement value N that feeds the TC4-to-7-segment display stage directly downstream.
- It also provides a sticky overflow flag for an LED and a one-cycle update strobe.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive clk cycles a synchronized key level must differ from the debounced level before the debounced level changes. Minimum 2. Board builds use 500000.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sw_b  input  4  operand B, two's complement, from slide switches. Sampled directly; quasi-static.
- key_add_n  input  1  raw active-low add button, asynchronous to clk.
- key_sub_n  input  1  raw active-low subtract button, asynchronous to clk.
- key_clr_n  input  1  raw active-low clear button, asynchronous to clk.
- N  output  4  accumulator value, two's complement. Drives the display stage.
- ovf  output  1  sticky signed-overflow flag.
- op_done  output  1  one-cycle pulse in the cycle N is updated.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (reset_n).
- Reset (reset_n=0, asynchronous, any time including mid-debounce):
  - N=0000, ovf=0, op_done=0.
  - Synchronizer flops=1, debounced levels=1 (released), debounce counters=0.
- Input conditioning, per key:
  - 2-flop synchronizer.
  - Debouncer:
    - If the synchronized value equals the debounced value, the counter clears to 0.
    - Otherwise the counter increments.
    - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the debounced value takes the synchronized value and the counter clears to 0.
  - A press event is a registered 1->0 transition of the debounced level: a one-cycle pulse, press_*.
  - A release generates no event.
  - Holding a key produces exactly one event.
- Latency: the accumulator registers update on the clk edge following the press pulse, and op_done is high in the cycle after that edge (same cycle N shows the new value). With a clean key falling before edge 0, N updates at edge 2+DEBOUNCE_CYCLES+1 (edge 7 for the default).
- Operation select, per cycle, priority order:
  1. press_clr: N<=0, ovf<=0, op_done<=1. Any add/sub press in the same cycle is discarded.
  2. press_add and press_sub together: both discarded; N, ovf unchanged; op_done<=0.
  3. press_add: N<=N+sw_b.
  4. press_sub: N<=N-sw_b.
  5. No press: hold; op_done<=0.
- Arithmetic:
  - Computed at 4 bits with wrap-around; the result is the low 4 bits.
  - Subtraction is N + ~sw_b + 1.
  - Overflow on add: N[3]==sw_b[3] and result[3]!=N[3].
  - Overflow on sub: N[3]!=sw_b[3] and result[3]!=N[3].
  - Subtracting -8 (1000) follows the same rule.
  - ovf is set on any overflowing op. It is cleared only by clear or reset. A non-overflowing op never clears it.
- sw_b is sampled in the same cycle as the press pulse. Changes of sw_b without a press have no effect.
- Reset asserted mid-operation aborts everything. After release, a key still held low must re-debounce. Its debounced level starts at released, so exactly one event is produced.

Test Plan:
- Reset: assert reset_n=0 mid-debounce with key_add_n low -> N=0000, ovf=0, op_done=0 immediately. After release with key still held: exactly one add, at edge 7 after release.
- Add sequence: sw_b=0011; add, add -> N=0110, ovf=0, op_done pulses twice, one cycle each. A third add -> N=1001 (-7), ovf=1. Then sw_b=1111, add -> N=1000, ovf stays 1.
- Subtract edge: clear, then sw_b=1000, sub -> N=1000, ovf=1. Clear -> N=0000, ovf=0. sw_b=0001, sub -> N=1111 (-1), ovf=0.
- Bounce rejection (DEBOUNCE_CYCLES=4):
  - key_add_n low for 3 cycles, then high -> no op_done, N unchanged.
  - Key low for 200 cycles with 2-cycle glitches only in the first 10 cycles -> exactly one op_done.
- Simultaneous events:
  - add and sub debounced presses land in the same cycle -> N, ovf unchanged, op_done=0.
  - clear and add in the same cycle -> N=0000, ovf=0, op_done=1.
- Hold/release: key held 1000 cycles and then released -> one op only; the release produces no op_done.
